// File: rtl/battleship_shot_engine.sv
// Shot-evaluation controller for the battleship game. It accepts one shot at
// a time, reads the ship-map memory, and tracks marks, hits and turns.
// Ports: clk, reset (sync, active-high), new_game restart pulse;
//   shot_valid/shot_ready/shot_row/shot_col shot handshake;
//   mem_rd_en/mem_addr/mem_rd_data ship-map read (1-cycle latency);
//   result_valid, hit, repeat_shot, hits_count, turns_left,
//   all_ships_sunk, turns_exhausted results for the game FSM.
// Optional macro SHOT_REPEAT_FREE_EN: repeat shots cost no turn.
module battleship_shot_engine #(
    parameter int GRID_BITS  = 3,
    parameter int MAX_TURNS  = 40,
    parameter int SHIP_CELLS = 17,
    localparam int AW = 2 * GRID_BITS,
    localparam int HW = $clog2(SHIP_CELLS + 1),
    localparam int TW = $clog2(MAX_TURNS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 shot_valid,
    output logic                 shot_ready,
    input  logic [GRID_BITS-1:0] shot_row,
    input  logic [GRID_BITS-1:0] shot_col,
    output logic                 mem_rd_en,
    output logic [AW-1:0]        mem_addr,
    input  logic                 mem_rd_data,
    output logic                 result_valid,
    output logic                 hit,
    output logic                 repeat_shot,
    output logic [HW-1:0]        hits_count,
    output logic [TW-1:0]        turns_left,
    output logic                 all_ships_sunk,
    output logic                 turns_exhausted
);

    localparam int NCELLS = 1 << AW;
    localparam logic [HW-1:0] SHIPS = HW'(SHIP_CELLS);
    localparam logic [TW-1:0] TURNS = TW'(MAX_TURNS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_REPORT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [NCELLS-1:0] marks_q, marks_d;
    logic              hit_q, hit_d;
    logic              rep_q, rep_d;
    logic [HW-1:0]     hits_q, hits_d;
    logic [TW-1:0]     turns_q, turns_d;
    logic              sunk_q, sunk_d;
    logic              exh_q, exh_d;
    logic              marked;
    logic              spend;

    assign marked = marks_q[addr_q];

`ifdef SHOT_REPEAT_FREE_EN
    assign spend = ~marked;
`else
    assign spend = 1'b1;
`endif

    // Results are computed at the end of WAIT so that they are already
    // registered when result_valid pulses in REPORT.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        marks_d = marks_q;
        hit_d   = hit_q;
        rep_d   = rep_q;
        hits_d  = hits_q;
        turns_d = turns_q;
        sunk_d  = sunk_q;
        exh_d   = exh_q;
        unique case (state_q)
            S_IDLE: begin
                if (shot_valid) begin
                    addr_d  = {shot_row, shot_col};
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_REPORT;
                hit_d   = ~marked & mem_rd_data;
                rep_d   = marked;
                if (!marked) begin
                    marks_d[addr_q] = 1'b1;
                end
                if (!marked && mem_rd_data && hits_q != SHIPS) begin
                    hits_d = hits_q + HW'(1);
                end
                if (spend && turns_q != '0) begin
                    turns_d = turns_q - TW'(1);
                end
                sunk_d = (hits_d == SHIPS);
                exh_d  = (turns_d == '0);
            end
            S_REPORT: begin
                state_d = (sunk_q | exh_q) ? S_DONE : S_IDLE;
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // Restart overrides everything, including a same-cycle shot.
        if (new_game) begin
            state_d = S_IDLE;
            marks_d = '0;
            hit_d   = 1'b0;
            rep_d   = 1'b0;
            hits_d  = '0;
            turns_d = TURNS;
            sunk_d  = 1'b0;
            exh_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            marks_q <= '0;
            hit_q   <= 1'b0;
            rep_q   <= 1'b0;
            hits_q  <= '0;
            turns_q <= TURNS;
            sunk_q  <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            marks_q <= marks_d;
            hit_q   <= hit_d;
            rep_q   <= rep_d;
            hits_q  <= hits_d;
            turns_q <= turns_d;
            sunk_q  <= sunk_d;
            exh_q   <= exh_d;
        end
    end

    assign shot_ready      = (state_q == S_IDLE) & ~reset;
    assign mem_rd_en       = (state_q == S_READ);
    assign mem_addr        = mem_rd_en ? addr_q : '0;
    assign result_valid    = (state_q == S_REPORT);
    assign hit             = hit_q;
    assign repeat_shot     = rep_q;
    assign hits_count      = hits_q;
    assign turns_left      = turns_q;
    assign all_ships_sunk  = sunk_q;
    assign turns_exhausted = exh_q;

endmodule
